// File: rtl/sync_binary_down_counter.sv
// Presettable synchronous binary down counter with borrow-out and a small load/run/expiry FSM.
// Optional feature macro: AUTO_RELOAD_EN (borrow edge reloads the last preset instead of wrapping to all-ones).
module sync_binary_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             mr,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             bo,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADED  = 2'd1,
    RUN     = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic             done_reg, done_next;
  logic [WIDTH-1:0] wrap_val;
  logic             q_zero, q_one;

  assign q_zero = (q_reg == '0);
  assign q_one  = (q_reg == WIDTH'(1));

`ifdef AUTO_RELOAD_EN
  logic [WIDTH-1:0] rld_reg;

  // Preset captured on every load; used as the value after a borrow.
  always_ff @(posedge clk or negedge mr) begin
    if (!mr) begin
      rld_reg <= '0;
    end else if (load) begin
      rld_reg <= d;
    end
  end

  assign wrap_val = rld_reg;
`else
  assign wrap_val = '1;
`endif

  // Counter datapath: load beats enable, enable beats hold.
  always_comb begin
    q_next    = q_reg;
    done_next = 1'b0;
    if (load) begin
      q_next = d;
    end else if (en) begin
      if (q_zero) begin
        q_next = wrap_val;
      end else begin
        q_next    = q_reg - WIDTH'(1);
        done_next = q_one;
      end
    end
  end

  always_ff @(posedge clk or negedge mr) begin
    if (!mr) begin
      q_reg    <= '0;
      done_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      done_reg <= done_next;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge mr) begin
    if (!mr) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state; an idle counter sitting at zero stays idle when it borrows.
  always_comb begin
    state_next = state_reg;
    if (load) begin
      state_next = (d == '0) ? IDLE : LOADED;
    end else if (en) begin
      if (!q_zero) begin
        state_next = q_one ? EXPIRED : RUN;
      end else if (state_reg != IDLE) begin
        state_next = RUN;
      end
    end
  end

  // FSM / datapath outputs
  always_comb begin
    busy = (state_reg == RUN);
    done = done_reg;
    q    = q_reg;
    bo   = en & q_zero & ~load;
  end

endmodule

// File: tb/tb_sync_binary_down_counter.sv
// Scoreboarded bench: a driver pushes model expectations, a monitor pops and compares each cycle.
// Also checks a two-stage cascade against a plain 8-bit modulo-256 down count.
module tb_sync_binary_down_counter;

  localparam int W = 4;
  localparam int M = 1 << W;

  localparam int PH_IDLE    = 0;
  localparam int PH_LOADED  = 1;
  localparam int PH_RUN     = 2;
  localparam int PH_EXPIRED = 3;

  logic         clk = 1'b0;
  logic         mr = 1'b0;
  logic         load = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] q;
  logic         bo, busy, done;

  logic         c_load = 1'b0;
  logic         c_en = 1'b0;
  logic [7:0]   c_d = '0;
  logic [W-1:0] c_q0, c_q1;
  logic         c_bo0, c_bo1, c_busy0, c_busy1, c_done0, c_done1;

  always #5 clk = ~clk;

  sync_binary_down_counter #(.WIDTH(W)) dut (
    .clk(clk), .mr(mr), .load(load), .en(en), .d(d),
    .q(q), .bo(bo), .busy(busy), .done(done)
  );

  sync_binary_down_counter #(.WIDTH(W)) lo_stage (
    .clk(clk), .mr(mr), .load(c_load), .en(c_en), .d(c_d[3:0]),
    .q(c_q0), .bo(c_bo0), .busy(c_busy0), .done(c_done0)
  );

  sync_binary_down_counter #(.WIDTH(W)) hi_stage (
    .clk(clk), .mr(mr), .load(c_load), .en(c_bo0), .d(c_d[7:4]),
    .q(c_q1), .bo(c_bo1), .busy(c_busy1), .done(c_done1)
  );

  typedef struct {
    int q;
    bit done;
    bit busy;
    bit bo;
    int cq;
    bit cbo;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;

  // Reference model state
  int m_q, m_rld, m_ph, c_cnt;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic void model_reset();
    m_q   = 0;
    m_rld = 0;
    m_ph  = PH_IDLE;
    c_cnt = 0;
  endfunction

  task automatic step(input bit l, input bit e, input int dv,
                      input bit cl, input bit ce, input int cd);
    exp_t x;
    bit   dn;
    bit   was_zero;
    @(negedge clk);
    mr = 1'b1;
    load = l; en = e; d = W'(dv);
    c_load = cl; c_en = ce; c_d = 8'(cd);
    dn = 1'b0;
    if (l) begin
      m_q   = dv % M;
      m_rld = m_q;
      m_ph  = (m_q == 0) ? PH_IDLE : PH_LOADED;
    end else if (e) begin
      was_zero = (m_q == 0);
      dn = (m_q == 1);
`ifdef AUTO_RELOAD_EN
      if (was_zero) m_q = m_rld;
      else m_q = m_q - 1;
`else
      m_q = (m_q + M - 1) % M;
`endif
      if (dn) m_ph = PH_EXPIRED;
      else if (!(was_zero && m_ph == PH_IDLE)) m_ph = PH_RUN;
    end
    if (cl) c_cnt = cd % 256;
    else if (ce) c_cnt = (c_cnt + 255) % 256;
    x.q    = m_q;
    x.done = dn;
    x.busy = (m_ph == PH_RUN);
    x.bo   = e && !l && (m_q == 0);
    x.cq   = c_cnt;
    x.cbo  = ce && !cl && (c_cnt == 0);
    sbq.push_back(x);
  endtask

  // Asynchronous reset mid-cycle, checked with no clock edge in between.
  task automatic async_reset_check();
    @(posedge clk);
    #2;
    mr = 1'b0;
    #1;
    check("async_rst_q", int'(q), 0);
    check("async_rst_done", int'(done), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_cascade_q", int'({c_q1, c_q0}), 0);
    model_reset();
  endtask

  // Monitor: outputs are presented every cycle, compared 1 time unit after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        $display("cyc %0d load=%0b en=%0b d=%0d q=%0d bo=%0b busy=%0b done=%0b cq=%02h cbo=%0b",
                 cyc, load, en, d, q, bo, busy, done, {c_q1, c_q0}, c_bo1);
        check("q", int'(q), e.q);
        check("done", int'(done), int'(e.done));
        check("busy", int'(busy), int'(e.busy));
        check("bo", int'(bo), int'(e.bo));
`ifndef AUTO_RELOAD_EN
        check("cascade_q", int'({c_q1, c_q0}), e.cq);
        check("cascade_bo", int'(c_bo1), int'(e.cbo));
`endif
      end
    end
  end

  initial begin
    bit l, e, cl, ce;
    int dv, cd;
    model_reset();
    #1;
    check("reset_q", int'(q), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);

    // Load 3 then count through zero and past it
    step(1, 0, 3, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);

    // Load beats enable on the same edge
    step(1, 0, 9, 0, 0, 0);
    step(1, 1, 6, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Enable toggling from 4 down to 0
    step(1, 0, 4, 0, 0, 0);
    for (int i = 0; i < 7; i++) step(0, (i % 2) == 0, 0, 0, 0, 0);

    // Load of zero: idle, no done; then borrow from idle
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);

    // Auto-reload style sequence (wraps in the default build)
    step(1, 0, 2, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0);

    // Reset mid-count at q=5
    step(1, 0, 9, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
    async_reset_check();

    // Cascade: load 8'h10 and count 17 cycles
    step(0, 0, 0, 1, 0, 8'h10);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 1, 0);

    // Randomized traffic on both counters
    for (int i = 0; i < 300; i++) begin
      l  = ($urandom_range(0, 7) == 0);
      e  = ($urandom_range(0, 3) != 0);
      dv = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, M - 1));
      cl = ($urandom_range(0, 31) == 0);
      ce = ($urandom_range(0, 3) != 0);
      cd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 255));
      step(l, e, dv, cl, ce, cd);
      if (i == 150) async_reset_check();
    end

    @(posedge clk);
    #3;
    check("scoreboard_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
